// File: rtl/mem_subsys_pkg.sv
// Shared types and helpers for the arbitrated unified instruction/data memory.
package mem_subsys_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam int WAIT_CNT_W = 4;

    // One byte-enable bit stretched across its 8 data bits.
    function automatic logic [7:0] lane_bits(input logic en);
        return {8{en}};
    endfunction

endpackage

// File: rtl/mem_subsys_arb_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr, ascends and wraps.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    int               idx;
    logic [IDX_W-1:0] cand;

    // NOTE: every output of a combinational block gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    always_comb begin
        gnt    = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            cand = IDX_W'(idx);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                winner    = cand;
            end
        end
    end

endmodule

// File: rtl/mem_subsys_arb.sv
// Unified word-organised RAM shared by NUM_PORTS requesters with round-robin
// arbitration, wait states, byte-lane writes and an out-of-range error.
module mem_subsys_arb
    import mem_subsys_pkg::*;
#(
    parameter int    NUM_PORTS   = 2,
    parameter int    DATA_W      = 32,
    parameter int    ADDR_W      = 32,
    parameter int    DEPTH       = 64,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_PORTS-1:0]                req,
    input  logic [NUM_PORTS-1:0]                we,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]    wdata,
    input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]  be,
    output logic [NUM_PORTS-1:0]                gnt,
    output logic [NUM_PORTS-1:0]                rvalid,
    output logic [DATA_W-1:0]                   rdata,
    output logic                                err
);

    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD_W-1:0] DEPTH_WORDS = WORD_W'(DEPTH);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    we_q, we_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [NB-1:0]           be_q, be_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [NUM_PORTS-1:0]    arb_gnt;
    logic [IDX_W-1:0]        arb_winner;
    logic                    arb_valid;
    logic                    in_range;
    logic                    ram_we;
    logic [RAM_AW-1:0]       ram_idx;
    logic [DATA_W-1:0]       wmask;
    logic                    unused_addr;

    logic [DATA_W-1:0]       ram [DEPTH];

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .req    (req),
        .ptr    (rr_q),
        .gnt    (arb_gnt),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Sub-word offset bits are deliberately ignored.
    assign unused_addr = ^addr;

    assign in_range = (word_q < DEPTH_WORDS);
    assign ram_idx  = word_q[RAM_AW-1:0];

    always_comb begin
        wmask = '0;
        for (int i = 0; i < NB; i++) begin
            wmask[8*i +: 8] = lane_bits(be_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        gnt     = '0;
        rvalid  = '0;
        ram_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt     = arb_gnt;
                    idx_d   = arb_winner;
                    we_d    = we[arb_winner];
                    word_d  = addr[arb_winner][ADDR_W-1:OFF_W];
                    wdata_d = wdata[arb_winner];
                    be_d    = be[arb_winner];
                    cnt_d   = WAIT_CNT_W'(WAIT_STATES);
                    rr_d    = (arb_winner == IDX_W'(NUM_PORTS - 1)) ? '0 : arb_winner + 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RESP;
                    err_d   = !in_range;
                    if (we_q) begin
                        rdata_d = '0;
                        ram_we  = in_range;
                    end else begin
                        rdata_d = in_range ? ram[ram_idx] : '0;
                    end
                end
            end
            RESP: begin
                rvalid[idx_q] = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; a reset
    // mid-transaction still blocks the write because ram_we follows state_q.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= (ram[ram_idx] & ~wmask) | (wdata_q & wmask);
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_subsys_arb.sv
// Directed bench: transaction table plus hand-written arbitration and reset sequences.
module tb_mem_subsys_arb;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0][3:0]  be;
    logic [1:0]       gnt, rvalid, gnt3, rvalid3;
    logic [31:0]      rdata, rdata3;
    logic             err, err3;

    int n_tests = 0;
    int n_fail  = 0;

    mem_subsys_arb #(.NUM_PORTS(2), .DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    mem_subsys_arb #(.NUM_PORTS(2), .DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  b;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    // Called at a negedge; runs one full handshake on the selected DUT.
    task automatic do_txn(input bit use3, input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int ws;
        int waited;
        int lat;
        logic [1:0] exp_oh;
        ws      = use3 ? 3 : 2;
        waited  = 0;
        lat     = 0;
        exp_oh  = 2'b01 << p;
        req     = '0;
        req[p]  = 1'b1;
        we[p]   = w;
        addr[p] = a;
        wdata[p] = wd;
        be[p]   = b;
        #1;
        while ((use3 ? gnt3 : gnt) == 2'b00 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " gnt"}, 32'(use3 ? gnt3 : gnt), 32'(exp_oh));
        if ((use3 ? gnt3 : gnt) == 2'b00) begin
            req = '0;
            return;
        end
        @(posedge clk);
        #1 req = '0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if ((use3 ? rvalid3 : rvalid) != 2'b00) break;
        end
        check({tag, " latency"}, 32'(lat), 32'(ws + 2));
        check({tag, " rvalid"}, 32'(use3 ? rvalid3 : rvalid), 32'(exp_oh));
        check({tag, " rdata"}, use3 ? rdata3 : rdata, exp_rdata);
        check({tag, " err"}, 32'(use3 ? err3 : err), 32'(exp_err));
    endtask

    vec_t tbl[15];

    initial begin
        int c;
        int n_g;
        int n_r;
        int g_cyc[16];
        int g_port[16];
        int seen;

        tbl[0]  = '{1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
        tbl[1]  = '{1, 1'b0, 32'h40, 32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
        tbl[2]  = '{0, 1'b1, 32'h14, 32'h11223344, 4'hF,    32'h0,        1'b0};
        tbl[3]  = '{1, 1'b1, 32'h14, 32'h0000AB00, 4'b0010, 32'h0,        1'b0};
        tbl[4]  = '{0, 1'b0, 32'h14, 32'h0,        4'h0,    32'h1122AB44, 1'b0};
        tbl[5]  = '{1, 1'b1, 32'h15, 32'hFF000000, 4'b1000, 32'h0,        1'b0};
        tbl[6]  = '{0, 1'b0, 32'h17, 32'h0,        4'h0,    32'hFF22AB44, 1'b0};
        tbl[7]  = '{1, 1'b1, 32'h14, 32'h12345678, 4'b0000, 32'h0,        1'b0};
        tbl[8]  = '{0, 1'b0, 32'h14, 32'h0,        4'h0,    32'hFF22AB44, 1'b0};
        tbl[9]  = '{0, 1'b1, 32'h00, 32'h0BADF00D, 4'hF,    32'h0,        1'b0};
        tbl[10] = '{1, 1'b0, 32'h100, 32'h0,       4'h0,    32'h0,        1'b1};
        tbl[11] = '{0, 1'b1, 32'h100, 32'hAAAAAAAA, 4'hF,   32'h0,        1'b1};
        tbl[12] = '{1, 1'b0, 32'h00, 32'h0,        4'h0,    32'h0BADF00D, 1'b0};
        tbl[13] = '{0, 1'b1, 32'hFC, 32'h5A5A5A5A, 4'hF,    32'h0,        1'b0};
        tbl[14] = '{1, 1'b0, 32'hFC, 32'h0,        4'h0,    32'h5A5A5A5A, 1'b0};

        reset = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        be    = '0;

        // Reset held for three cycles with no requests.
        repeat (3) begin
            @(negedge clk);
            check("reset gnt", 32'(gnt), 32'h0);
            check("reset rvalid", 32'(rvalid), 32'h0);
            check("reset rdata", rdata, 32'h0);
            check("reset err", 32'(err), 32'h0);
        end
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            do_txn(1'b0, tbl[i].port, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].b,
                   tbl[i].exp_rdata, tbl[i].exp_err, $sformatf("vec%0d", i));
        end

        // Both ports request continuously from reset: grants must alternate.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        we      = 2'b00;
        addr[0] = 32'h00;
        addr[1] = 32'h40;
        req     = 2'b11;
        n_g = 0;
        n_r = 0;
        for (c = 0; c < 24; c++) begin
            #1;
            if (gnt != 2'b00 && n_g < 16) begin
                check("rr grant", 32'(gnt), (n_g % 2 == 0) ? 32'h1 : 32'h2);
                if (n_g > 0) check("rr spacing", 32'(c - g_cyc[n_g-1]), 32'd5);
                g_cyc[n_g]  = c;
                g_port[n_g] = (gnt == 2'b10) ? 1 : 0;
                n_g++;
            end
            if (rvalid != 2'b00) begin
                if (n_r < n_g) begin
                    check("rr rvalid port", 32'(rvalid), 32'(2'b01 << g_port[n_r]));
                    check("rr rvalid delay", 32'(c - g_cyc[n_r]), 32'd4);
                    check("rr rdata", rdata, (g_port[n_r] == 1) ? 32'hDEADBEEF : 32'h0BADF00D);
                end else begin
                    check("rr rvalid without grant", 32'(rvalid), 32'h0);
                end
                n_r++;
            end
            @(negedge clk);
        end
        check("rr grant count", 32'(n_g >= 4), 32'h1);
        req = '0;
        repeat (8) @(negedge clk);

        // Reset during the second BUSY cycle of a WAIT_STATES=3 write.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_txn(1'b1, 1, 1'b1, 32'h08, 32'h00000000, 4'hF, 32'h0, 1'b0, "ws3 clear");
        @(negedge clk);
        req      = 2'b10;
        we[1]    = 1'b1;
        addr[1]  = 32'h08;
        wdata[1] = 32'hCAFEF00D;
        be[1]    = 4'hF;
        #1;
        seen = 0;
        while (gnt3 == 2'b00 && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        check("ws3 abort gnt", 32'(gnt3), 32'h2);
        @(posedge clk);
        #1 req = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rvalid3 != 2'b00) seen++;
        end
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rvalid3 != 2'b00) seen++;
        end
        check("ws3 no rvalid after abort", 32'(seen), 32'h0);
        do_txn(1'b1, 1, 1'b0, 32'h08, 32'h0, 4'h0, 32'h00000000, 1'b0, "ws3 readback");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
